// File: rtl/mul_result_packer.sv
// Buffers signed 64-bit multiplier products in a small FIFO, flags products that
// do not fit in 32 signed bits, and streams each product as a low beat then a high beat.
module mul_result_packer #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_res,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          out_hi,
  output logic          out_last,
  output logic          out_ovf,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LO    = 2'd1,
    ST_HI    = 2'd2
  } state_t;

  // Entry layout: bit 64 is the overflow flag, bits 63..0 the product.
  logic [64:0]   mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  state_t        state_r;
  state_t        state_s;
  logic          push_s;
  logic          pop_s;
  logic          ovf_s;
  logic [CW-1:0] remain_s;
  logic [64:0]   head_s;

  // Overflow means bits 63..31 are not a pure sign extension.
  function automatic logic calc_ovf(input logic [63:0] res);
    calc_ovf = ~(&res[63:31] | ~|res[63:31]);
  endfunction

  assign in_ready = (count_r != CW'(DEPTH));
  assign push_s   = in_valid && in_ready;
  assign ovf_s    = calc_ovf(in_res);
  assign remain_s = count_r + CW'(push_s) - CW'(1);
  assign head_s   = mem_r[rd_ptr_r];

  // Next-state logic for the beat sequencer; a push into an empty FIFO starts LO at once.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (push_s || (count_r != CW'(0))) begin
          state_s = ST_LO;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_LO: begin
        if (out_ready) begin
          state_s = ST_HI;
        end else begin
          state_s = ST_LO;
        end
      end
      ST_HI: begin
        if (out_ready) begin
          pop_s   = 1'b1;
          state_s = (remain_s != CW'(0)) ? ST_LO : ST_EMPTY;
        end else begin
          state_s = ST_HI;
        end
      end
      default: begin
        state_s = ST_EMPTY;
        pop_s   = 1'b0;
      end
    endcase
  end

  // Sequencer state, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_EMPTY;
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CW'(1);
      end else if (pop_s && !push_s) begin
        count_r <= count_r - CW'(1);
      end
    end
  end

  // Product storage; contents are only observed while the sequencer is non-empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {ovf_s, in_res};
    end
  end

  // Beat outputs come from the head entry and the registered state only.
  always_comb begin
    out_data = 32'h0000_0000;
    out_ovf  = 1'b0;
    case (state_r)
      ST_LO: begin
        out_data = head_s[31:0];
        out_ovf  = head_s[64];
      end
      ST_HI: begin
        out_data = head_s[63:32];
        out_ovf  = head_s[64];
      end
      default: begin
        out_data = 32'h0000_0000;
        out_ovf  = 1'b0;
      end
    endcase
  end

  assign out_valid = (state_r != ST_EMPTY);
  assign out_hi    = (state_r == ST_HI);
  assign out_last  = (state_r == ST_HI);
  assign count     = count_r;

endmodule

// File: tb/tb_mul_result_packer.sv
// Directed and randomized checks of mul_result_packer against a queue-based
// model of the products held and the beat currently offered.
module tb_mul_result_packer;

  localparam int DEPTH = 2;
  localparam int CW    = 2;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_res;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          out_hi;
  logic          out_last;
  logic          out_ovf;
  logic [CW-1:0] count;

  int tests;
  int fails;

  logic [63:0] q[$];
  logic        hi_phase;
  logic        last_push;

  mul_result_packer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_res(in_res), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_hi(out_hi), .out_last(out_last),
    .out_ovf(out_ovf), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic model_ovf(input logic [63:0] v);
    logic signed [63:0] s;
    s = v;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs against the model, then advance model by the handshakes.
  task automatic step();
    logic push_m;
    logic beat_m;
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
    check("count", 64'(count), 64'(q.size()));
    check("count_le_depth", 64'(count <= CW'(DEPTH)), 64'd1);
    if (q.size() != 0) begin
      check("out_data", 64'(out_data), hi_phase ? 64'(q[0][63:32]) : 64'(q[0][31:0]));
      check("out_hi", 64'(out_hi), 64'(hi_phase));
      check("out_last", 64'(out_last), 64'(hi_phase));
      check("out_ovf", 64'(out_ovf), 64'(model_ovf(q[0])));
    end
    push_m = in_valid && (q.size() != DEPTH);
    beat_m = out_ready && (q.size() != 0);
    @(posedge clk);
    #1;
    if (beat_m) begin
      if (hi_phase) begin
        void'(q.pop_front());
        hi_phase = 1'b0;
      end else begin
        hi_phase = 1'b1;
      end
    end
    if (push_m) q.push_back(in_res);
    last_push = push_m;
  endtask

  task automatic push(input logic [63:0] v);
    int n;
    in_valid = 1'b1;
    in_res   = v;
    n = 0;
    last_push = 1'b0;
    while (!last_push && n < 50) begin
      step();
      n++;
    end
    check("push_timeout", 64'(last_push), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input logic rand_ready);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    out_ready = 1'b1;
    check("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic ovf_case(input logic [63:0] v, input logic e);
    push(v);
    for (int b = 0; b < 2; b++) begin
      check("ovf_fixed", 64'(out_ovf), 64'(e));
      step();
    end
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    tests     = 0;
    fails     = 0;
    hi_phase  = 1'b0;
    last_push = 1'b0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_res    = 64'h0;
    out_ready = 1'b0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_hi", 64'(out_hi), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single small product, pushed on the first edge after reset release.
    out_ready = 1'b1;
    push(64'h0000_0000_0000_0005);
    check("single_lo_data", 64'(out_data), 64'h5);
    check("single_lo_hi", 64'(out_hi), 64'd0);
    check("single_count1", 64'(count), 64'd1);
    step();
    check("single_hi_data", 64'(out_data), 64'h0);
    check("single_hi_last", 64'(out_last), 64'd1);
    step();
    check("single_count0", 64'(count), 64'd0);
    check("single_empty", 64'(out_valid), 64'd0);

    ovf_case(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    ovf_case(64'hFFFF_FFFF_8000_0000, 1'b0);
    ovf_case(64'h0000_0000_8000_0000, 1'b1);
    ovf_case(64'h7FFF_FFFF_0000_0000, 1'b1);
    ovf_case(64'h0000_0000_7FFF_FFFF, 1'b0);

    // Backpressure and full FIFO.
    a = 64'h1234_5678_9ABC_DEF0;
    b = 64'hFEDC_BA98_7654_3210;
    c = 64'h0000_0000_CAFE_F00D;
    out_ready = 1'b0;
    push(a);
    push(b);
    check("full_count", 64'(count), 64'd2);
    check("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_res   = c;
    repeat (10) step();
    check("hold_a_lo", 64'(out_data), 64'(a[31:0]));
    out_ready = 1'b1;
    step();
    check("a_hi_shown", 64'(out_data), 64'(a[63:32]));
    check("a_hi_in_ready", 64'(in_ready), 64'd0);
    step();
    check("ready_after_a_hi", 64'(in_ready), 64'd1);
    step();
    check("c_pushed_count", 64'(count), 64'd2);
    in_valid = 1'b0;
    drain(1'b0);

    // Push landing on the same edge as a pop keeps count steady.
    push(64'h0000_0001_0000_0002);
    step();
    in_valid = 1'b1;
    in_res   = 64'h0000_0003_0000_0004;
    step();
    in_valid = 1'b0;
    check("simul_count", 64'(count), 64'd1);
    drain(1'b0);

    // Pointer wrap with random products and random backpressure.
    for (int i = 0; i < 10; i++) begin
      int n;
      if (i % 3 == 0) in_res = {{32{1'($urandom_range(0, 1))}}, 32'($urandom)};
      else in_res = {32'($urandom), 32'($urandom)};
      in_valid = 1'b1;
      n = 0;
      last_push = 1'b0;
      while (!last_push && n < 50) begin
        out_ready = 1'($urandom_range(0, 1));
        step();
        n++;
      end
      check("wrap_push_timeout", 64'(last_push), 64'd1);
    end
    in_valid = 1'b0;
    drain(1'b1);

    // Reset in the middle of a packet with two entries held.
    out_ready = 1'b0;
    push(64'hAAAA_AAAA_BBBB_BBBB);
    push(64'hCCCC_CCCC_DDDD_DDDD);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("mid_in_hi", 64'(out_hi), 64'd1);
    check("mid_count", 64'(count), 64'd2);
    #2;
    reset = 1'b0;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_count", 64'(count), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd1);
    check("async_out_data", 64'(out_data), 64'd0);
    q.delete();
    hi_phase = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    push(64'hFFFF_FFFE_0000_0001);
    check("post_rst_lo", 64'(out_data), 64'h0000_0001);
    drain(1'b0);
    check("post_rst_empty", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
